// File: rtl/fq_div_pkg.sv
// +--------------------------------------------------------------------------+
// | fq_div_pkg: shared FSM state encoding and ratio limit for fq_div_ctrl    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package fq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } fq_state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/fq_div_phase.sv
// +--------------------------------------------------------------------------+
// | fq_div_phase: phase counter producing registered div_clk / div_tick      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fq_div_phase #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_i,
  input  logic         act_d_i,
  input  logic [W-1:0] div_i,
  input  logic [W-1:0] div_d_i,
  output logic         boundary_o,
  output logic         div_clk_o,
  output logic         div_tick_o
);

  localparam logic [W-1:0] C_ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         boundary;

  assign boundary = run_i && (cnt_q == (div_i - C_ONE));

  // Outputs are computed from next-cycle count and ratio so they leave flops.
  always_comb begin
    cnt_d = '0;
    if (act_d_i && run_i && !boundary) begin
      cnt_d = cnt_q + C_ONE;
    end
    clk_d  = act_d_i && (cnt_d < (div_d_i >> 1));
    tick_d = act_d_i && (cnt_d == (div_d_i - C_ONE));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign boundary_o = boundary;
  assign div_clk_o  = clk_q;
  assign div_tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/fq_div_ctrl.sv
// +--------------------------------------------------------------------------+
// | fq_div_ctrl: glitch-free run-time programmable clock divider controller  |
// | optional: FQ_DIV_PERIOD_CNT_EN adds period_cnt output      rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module fq_div_ctrl
  import fq_div_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic         org_clk,
  input  logic         sys_rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         div_clk,
  output logic         div_tick,
  output logic         busy,
  output logic [W-1:0] cur_div
`ifdef FQ_DIV_PERIOD_CNT_EN
  ,
  output logic [31:0]  period_cnt
`endif
);

  localparam logic [W-1:0] C_MIN = W'(MIN_DIV);
  localparam logic [W-1:0] C_DEF = W'(DEF_DIV);

  fq_state_e    state_q, state_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         pend_vld_q, pend_vld_d;
  logic         cfg_err_q, cfg_err_d;

  logic accept;
  logic ratio_bad;
  logic good_acc;
  logic boundary;
  logic stop_done;

  assign accept    = cfg_valid && cfg_ready;
  assign ratio_bad = cfg_div < C_MIN;
  assign good_acc  = accept && !ratio_bad;
  assign stop_done = (state_q == STOP) && boundary && !en;

  // FSM: state register
  always_ff @(posedge org_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en)           state_d = STOP;
        else if (good_acc) state_d = PEND;
      end
      PEND: begin
        if (!en)           state_d = STOP;
        else if (boundary) state_d = RUN;
      end
      STOP: begin
        // Re-enable resumes without restarting the period in progress.
        if (en) begin
          if ((pend_vld_q && !boundary) || good_acc) state_d = PEND;
          else                                      state_d = RUN;
        end else if (boundary) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready = (state_q != PEND) && !pend_vld_q;
    busy      = (state_q != IDLE);
  end

  // Ratio datapath: a ratio landing on the final STOP boundary goes straight to
  // cur_div, since the divider is about to idle and nothing is left to protect.
  always_comb begin
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    cfg_err_d  = accept && ratio_bad;
    if (boundary && pend_vld_q) begin
      cur_div_d  = pend_div_q;
      pend_vld_d = 1'b0;
    end
    if (good_acc) begin
      if ((state_q == IDLE) || stop_done) begin
        cur_div_d = cfg_div;
      end else begin
        pend_div_d = cfg_div;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge org_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cur_div_q  <= C_DEF;
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  fq_div_phase #(
    .W (W)
  ) u_phase (
    .clk_i      (org_clk),
    .rst_i      (sys_rst),
    .run_i      (state_q != IDLE),
    .act_d_i    (state_d != IDLE),
    .div_i      (cur_div_q),
    .div_d_i    (cur_div_d),
    .boundary_o (boundary),
    .div_clk_o  (div_clk),
    .div_tick_o (div_tick)
  );

  assign cfg_err = cfg_err_q;
  assign cur_div = cur_div_q;

`ifdef FQ_DIV_PERIOD_CNT_EN
  logic [31:0] period_cnt_q;

  always_ff @(posedge org_clk or posedge sys_rst) begin
    if (sys_rst) begin
      period_cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == RUN)) begin
      period_cnt_q <= '0;
    end else if (div_tick) begin
      period_cnt_q <= period_cnt_q + 32'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fq_div_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_fq_div_ctrl: directed vector bench for fq_div_ctrl      rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fq_div_ctrl;

  logic        org_clk;
  logic        sys_rst;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic        div_clk;
  logic        div_tick;
  logic        busy;
  logic [15:0] cur_div;
`ifdef FQ_DIV_PERIOD_CNT_EN
  logic [31:0] period_cnt;
`endif

  fq_div_ctrl #(
    .W       (16),
    .DEF_DIV (2)
  ) dut (
    .org_clk   (org_clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_clk   (div_clk),
    .div_tick  (div_tick),
    .busy      (busy),
    .cur_div   (cur_div)
`ifdef FQ_DIV_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  initial org_clk = 1'b0;
  always #5 org_clk = ~org_clk;

  typedef struct packed {
    logic        en;
    logic        vld;
    logic [15:0] div;
    logic        rdy;
    logic        err;
    logic        dclk;
    logic        tick;
    logic        busy;
    logic [15:0] cur;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ticks;

  task automatic add(input logic e, input logic v, input logic [15:0] d,
                     input logic rdy, input logic err, input logic dclk,
                     input logic tick, input logic bsy, input logic [15:0] cur);
    vec_t r;
    r.en = e; r.vld = v; r.div = d;
    r.rdy = rdy; r.err = err; r.dclk = dclk; r.tick = tick; r.busy = bsy; r.cur = cur;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // en vld div | rdy err clk tick busy cur   (outputs seen in that cycle)
    add(1,0,0,  1,0,0,0,0,2);  // 0  reset state, enable
    add(1,0,0,  1,0,1,0,1,2);  // 1  N=2 cnt0
    add(1,0,0,  1,0,0,1,1,2);
    add(1,0,0,  1,0,1,0,1,2);
    add(1,1,4,  1,0,0,1,1,2);  // 4  accept 4 on boundary cycle
    add(1,0,0,  0,0,1,0,1,2);  //    still N=2, queue held
    add(1,0,0,  0,0,0,1,1,2);  //    applied at this boundary
    add(1,0,0,  1,0,1,0,1,4);  // 7  N=4 cnt0
    add(1,1,6,  1,0,1,0,1,4);  // 8  accept 6 at cnt1
    add(1,0,0,  0,0,0,0,1,4);
    add(1,0,0,  0,0,0,1,1,4);
    add(1,0,0,  1,0,1,0,1,6);  // 11 N=6 cnt0
    add(1,1,1,  1,0,1,0,1,6);  // 12 bad ratio 1
    add(1,1,0,  1,1,1,0,1,6);  // 13 bad ratio 0
    add(1,1,5,  1,1,0,0,1,6);  // 14 accept 5 at cnt3
    add(1,0,0,  0,0,0,0,1,6);
    add(1,0,0,  0,0,0,1,1,6);
    add(1,0,0,  1,0,1,0,1,5);  // 17 N=5 cnt0
    add(0,0,0,  1,0,1,0,1,5);  // 18 drop en at cnt1
    add(0,0,0,  1,0,0,0,1,5);
    add(0,0,0,  1,0,0,0,1,5);
    add(0,0,0,  1,0,0,1,1,5);
    add(0,1,4,  1,0,0,0,0,5);  // 22 idle, write 4 directly
    add(1,0,0,  1,0,0,0,0,4);
    add(1,0,0,  1,0,1,0,1,4);  // 24 N=4 cnt0
    add(0,1,8,  1,0,1,0,1,4);  // 25 stop and queue 8 together
    add(0,0,0,  0,0,0,0,1,4);
    add(0,0,0,  0,0,0,1,1,4);
    add(1,0,0,  1,0,0,0,0,8);  // 28 idle with 8, re-enable
    add(1,0,0,  1,0,1,0,1,8);
    add(0,0,0,  1,0,1,0,1,8);  // 30 drop en ...
    add(1,0,0,  1,0,1,0,1,8);  //    ... and raise it again in STOP
    add(1,0,0,  1,0,1,0,1,8);
    add(1,0,0,  1,0,0,0,1,8);
    add(1,0,0,  1,0,0,0,1,8);
    add(1,0,0,  1,0,0,0,1,8);
    add(1,0,0,  1,0,0,1,1,8);
    add(0,0,0,  1,0,1,0,1,8);  // 37 period unchanged, new one starts

    sys_rst   = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    repeat (2) @(negedge org_clk);
    sys_rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      chk($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 32'(vq[i].rdy));
      chk($sformatf("v%0d cfg_err",   i), 32'(cfg_err),   32'(vq[i].err));
      chk($sformatf("v%0d div_clk",   i), 32'(div_clk),   32'(vq[i].dclk));
      chk($sformatf("v%0d div_tick",  i), 32'(div_tick),  32'(vq[i].tick));
      chk($sformatf("v%0d busy",      i), 32'(busy),      32'(vq[i].busy));
      chk($sformatf("v%0d cur_div",   i), 32'(cur_div),   32'(vq[i].cur));
      en        = vq[i].en;
      cfg_valid = vq[i].vld;
      cfg_div   = vq[i].div;
      @(negedge org_clk);
    end

    // Async reset mid-period with a ratio queued.
    sys_rst = 1'b1;
    en = 1'b0; cfg_valid = 1'b0;
    @(negedge org_clk);
    sys_rst = 1'b0;
    en = 1'b1; cfg_valid = 1'b1; cfg_div = 16'd6;
    @(negedge org_clk);
    chk("rst6 cur_div start", 32'(cur_div), 32'd6);
    chk("rst6 div_clk cnt0", 32'(div_clk), 32'd1);
    cfg_div = 16'd3;
    @(negedge org_clk);
    cfg_valid = 1'b0;
    chk("rst6 cfg_ready queued", 32'(cfg_ready), 32'd0);
    @(negedge org_clk);
    chk("rst6 div_clk cnt2", 32'(div_clk), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst6 div_clk async", 32'(div_clk), 32'd0);
    chk("rst6 busy async", 32'(busy), 32'd0);
    chk("rst6 cfg_ready async", 32'(cfg_ready), 32'd1);
    chk("rst6 cur_div async", 32'(cur_div), 32'd2);
    chk("rst6 div_tick async", 32'(div_tick), 32'd0);
`ifdef FQ_DIV_PERIOD_CNT_EN
    chk("rst6 period_cnt async", period_cnt, 32'd0);
`endif
    @(negedge org_clk);
    sys_rst = 1'b0;

    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge org_clk);
      if (div_tick) ticks++;
      if (k <= 3) begin
        chk($sformatf("post k%0d div_clk", k), 32'(div_clk), (k % 2 == 1) ? 32'd1 : 32'd0);
      end
    end
    chk("post tick count", 32'(ticks), 32'd10);
    chk("post queue lost", 32'(cur_div), 32'd2);
    @(negedge org_clk);
`ifdef FQ_DIV_PERIOD_CNT_EN
    chk("post period_cnt", period_cnt, 32'd10);
`endif
    chk("post busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
